// File: rtl/my_gate_pkg.sv
// Shared definitions for the gate unit and its bench: the operation code enum.
package my_gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_MUX  = 3'd4,
        OP_DMUX = 3'd5,
        OP_NAND = 3'd6,
        OP_NOR  = 3'd7
    } op_t;

endpackage

// File: rtl/my_gate_fifo.sv
// Result queue for my_gate_unit: DEPTH entries of WIDTH bits, valid/ready on both sides.
// in_ready depends only on the stored count, so a full queue never accepts in the cycle it pops.
module my_gate_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    assign in_ready_o  = (count_q < FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/my_gate_unit.sv
// Bitwise gate unit: combinational compute per op code, results queued in my_gate_fifo.
// Optional MY_GATE_UNIT_PARITY_EN adds out_parity, stored per entry at push time.
module my_gate_unit
    import my_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1
`ifdef MY_GATE_UNIT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

`ifdef MY_GATE_UNIT_PARITY_EN
    localparam int ENTRY_W = 2 * WIDTH + 1;
`else
    localparam int ENTRY_W = 2 * WIDTH;
`endif

    logic [WIDTH-1:0]   res0;
    logic [WIDTH-1:0]   res1;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    always_comb begin
        res0 = '0;
        res1 = '0;
        case (op_t'(op))
            OP_NOT:  res0 = ~in0;
            OP_AND:  res0 = in0 & in1;
            OP_OR:   res0 = in0 | in1;
            OP_XOR:  res0 = in0 ^ in1;
            OP_MUX:  res0 = (in0 & ~sel) | (in1 & sel);
            OP_DMUX: begin
                res0 = in0 & ~sel;
                res1 = in0 & sel;
            end
            OP_NAND: res0 = ~(in0 & in1);
            OP_NOR:  res0 = ~(in0 | in1);
            default: res0 = '0;
        endcase
    end

`ifdef MY_GATE_UNIT_PARITY_EN
    assign push_entry = {^res0, res1, res0};
    assign out_parity = head_entry[2*WIDTH];
`else
    assign push_entry = {res1, res0};
`endif

    // The queue zeroes its head data when empty, which gives the idle output values.
    my_gate_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (push_entry),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (head_entry)
    );

    assign out0 = head_entry[WIDTH-1:0];
    assign out1 = head_entry[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_my_gate_unit.sv
// Bench for my_gate_unit: a DEPTH=2 and a DEPTH=3 instance share one stimulus stream
// and are checked every cycle against queue-based reference models.
module tb_my_gate_unit;
    import my_gate_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] sel;
    logic       out_ready;

    logic       inReadyA, outValidA, parityA;
    logic [7:0] out0A, out1A;
    logic       inReadyB, outValidB, parityB;
    logic [7:0] out0B, out1B;

    int errors = 0;
    int checks = 0;

    logic [15:0] qA[$];
    logic [15:0] qB[$];

    my_gate_unit #(.WIDTH(8), .DEPTH(2)) dutA (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (inReadyA),
        .op         (op),
        .in0        (in0),
        .in1        (in1),
        .sel        (sel),
        .out_valid  (outValidA),
        .out_ready  (out_ready),
        .out0       (out0A),
        .out1       (out1A)
`ifdef MY_GATE_UNIT_PARITY_EN
        ,
        .out_parity (parityA)
`endif
    );

    my_gate_unit #(.WIDTH(8), .DEPTH(3)) dutB (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (inReadyB),
        .op         (op),
        .in0        (in0),
        .in1        (in1),
        .sel        (sel),
        .out_valid  (outValidB),
        .out_ready  (out_ready),
        .out0       (out0B),
        .out1       (out1B)
`ifdef MY_GATE_UNIT_PARITY_EN
        ,
        .out_parity (parityB)
`endif
    );

`ifndef MY_GATE_UNIT_PARITY_EN
    assign parityA = 1'b0;
    assign parityB = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the op table: {out1, out0}.
    function automatic logic [15:0] refResult(input logic [2:0] o, input logic [7:0] a,
                                              input logic [7:0] b, input logic [7:0] s);
        logic [7:0] r0;
        logic [7:0] r1;
        r0 = 8'h00;
        r1 = 8'h00;
        case (o)
            3'd0: r0 = ~a;
            3'd1: r0 = a & b;
            3'd2: r0 = a | b;
            3'd3: r0 = a ^ b;
            3'd4: for (int i = 0; i < 8; i++) r0[i] = s[i] ? b[i] : a[i];
            3'd5: begin r0 = a & ~s; r1 = a & s; end
            3'd6: r0 = ~(a & b);
            default: r0 = ~(a | b);
        endcase
        return {r1, r0};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] headA;
        logic [15:0] headB;
        headA = (qA.size() > 0) ? qA[0] : 16'h0000;
        headB = (qB.size() > 0) ? qB[0] : 16'h0000;
        chk({tag, "_rdyA"}, 16'(inReadyA), 16'(qA.size() < 2));
        chk({tag, "_vldA"}, 16'(outValidA), 16'(qA.size() > 0));
        chk({tag, "_outA"}, {out1A, out0A}, headA);
        chk({tag, "_rdyB"}, 16'(inReadyB), 16'(qB.size() < 3));
        chk({tag, "_vldB"}, 16'(outValidB), 16'(qB.size() > 0));
        chk({tag, "_outB"}, {out1B, out0B}, headB);
`ifdef MY_GATE_UNIT_PARITY_EN
        chk({tag, "_parA"}, 16'(parityA), 16'(^headA[7:0]));
        chk({tag, "_parB"}, 16'(parityB), 16'(^headB[7:0]));
`endif
    endtask

    // One clock cycle: check the current state, drive inputs, advance models on the edge.
    task automatic applyStimulus(input string tag, input logic v, input logic [2:0] o,
                                 input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                                 input logic r, input logic rst);
        logic accA, accB, popA, popB;
        logic [15:0] res;
        checkOutput(tag);
        in_valid  = v;
        op        = o;
        in0       = a;
        in1       = b;
        sel       = s;
        out_ready = r;
        rst_n     = rst;
        res  = refResult(o, a, b, s);
        accA = v && (qA.size() < 2);
        accB = v && (qB.size() < 3);
        popA = r && (qA.size() > 0);
        popB = r && (qB.size() > 0);
        @(posedge clk);
        if (!rst) begin
            qA.delete();
            qB.delete();
        end else begin
            if (popA) void'(qA.pop_front());
            if (popB) void'(qB.pop_front());
            if (accA) qA.push_back(res);
            if (accB) qB.push_back(res);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        in0       = 8'h00;
        in1       = 8'h00;
        sel       = 8'h00;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);

        chk("rst_rdyA", 16'(inReadyA), 16'h1);
        chk("rst_vldA", 16'(outValidA), 16'h0);
        chk("rst_outA", {out1A, out0A}, 16'h0000);
        applyStimulus("idle", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);

        applyStimulus("and", 1'b1, OP_AND, 8'hF0, 8'h3C, 8'h00, 1'b1, 1'b1);
        chk("and_vld", 16'(outValidA), 16'h1);
        chk("and_out", {out1A, out0A}, 16'h0030);

        applyStimulus("dmux", 1'b1, OP_DMUX, 8'hFF, 8'h00, 8'h0F, 1'b1, 1'b1);
        chk("dmux_out", {out1A, out0A}, 16'h0FF0);
        applyStimulus("mux", 1'b1, OP_MUX, 8'hAA, 8'h55, 8'h0F, 1'b1, 1'b1);
        chk("mux_out", {out1A, out0A}, 16'h00A5);
        applyStimulus("drain", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);

        applyStimulus("fill1", 1'b1, OP_NOT, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1);
        applyStimulus("fill2", 1'b1, OP_OR, 8'h12, 8'h21, 8'h00, 1'b0, 1'b1);
        chk("full_rdyA", 16'(inReadyA), 16'h0);
        applyStimulus("fill3", 1'b1, OP_XOR, 8'h33, 8'h0F, 8'h00, 1'b0, 1'b1);
        chk("full_headA", {out1A, out0A}, 16'h00FE);
        chk("full_rdyB", 16'(inReadyB), 16'h0);

        applyStimulus("fullpop", 1'b1, OP_NAND, 8'hFF, 8'h0F, 8'h00, 1'b1, 1'b1);
        chk("fullpop_rdyA", 16'(inReadyA), 16'h1);
        chk("fullpop_headA", {out1A, out0A}, 16'h0033);

        applyStimulus("preRst", 1'b1, OP_NOR, 8'h0F, 8'h30, 8'h00, 1'b0, 1'b1);
        applyStimulus("rst", 1'b1, OP_AND, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
        chk("midrst_vldA", 16'(outValidA), 16'h0);
        chk("midrst_rdyA", 16'(inReadyA), 16'h1);
        chk("midrst_vldB", 16'(outValidB), 16'h0);
        applyStimulus("postRst1", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        applyStimulus("postRst2", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

`ifdef MY_GATE_UNIT_PARITY_EN
        applyStimulus("par", 1'b1, OP_XOR, 8'h07, 8'h00, 8'h00, 1'b1, 1'b1);
        chk("par_out", {out1A, out0A}, 16'h0007);
        chk("par_bit", 16'(parityA), 16'h1);
        applyStimulus("parDrain", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 100; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          8'($urandom), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)), 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus("final", 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        end
        checkOutput("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
